// File: rtl/inst_fetch_resp_pkg.sv
// inst_fetch_resp_pkg
//   Shared widths and the queue entry layout for the instruction fetch
//   responder (inst_fetch_resp and its fetch queue).
//   No ports; imported with "import inst_fetch_resp_pkg::*;".
package inst_fetch_resp_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  // One in-order queue slot. done=1 means the entry can be handed to decode
  // (either its bus data has returned, or it is an ADEF entry that never
  // goes to the bus).
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
    logic                   adef;
    logic                   done;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_resp_fetch_queue.sv
// inst_fetch_resp_fetch_queue
//   In-order circular buffer between the fetch bus and decode. Entries are
//   allocated at the tail, completed out of the bus return stream into the
//   oldest entry that is still waiting, and popped from the head.
// Ports
//   clk, rst           clock, synchronous active-low reset
//   flush_i            drop every entry (wins over alloc/fill/pop)
//   alloc_i            allocate tail entry {alloc_pc_i, alloc_adef_i}
//   fill_i             write fill_inst_i into the oldest not-done entry
//   pop_i              retire the head entry
//   slot_free_o        fewer than QDEPTH entries allocated (registered count)
//   head_valid_o       head entry exists and is done
//   head_pc_o/inst_o/adef_o  head entry payload
module inst_fetch_resp_fetch_queue
  import inst_fetch_resp_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   alloc_i,
  input  logic [INST_ADDR_W-1:0] alloc_pc_i,
  input  logic                   alloc_adef_i,
  input  logic                   fill_i,
  input  logic [INST_W-1:0]      fill_inst_i,
  input  logic                   pop_i,
  output logic                   slot_free_o,
  output logic                   head_valid_o,
  output logic [INST_ADDR_W-1:0] head_pc_o,
  output logic [INST_W-1:0]      head_inst_o,
  output logic                   head_adef_o
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  fetch_entry_t     ent_q [QDEPTH];
  fetch_entry_t     ent_d [QDEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] fill_idx;
  logic             fill_hit;

  // Bus data returns in request order, and ADEF entries are born done, so the
  // target of a return is the first not-done entry walking from the head.
  always_comb begin
    fill_idx = head_q;
    fill_hit = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (!fill_hit && (CNT_W'(i) < cnt_q) && !ent_q[head_q + PTR_W'(i)].done) begin
        fill_idx = head_q + PTR_W'(i);
        fill_hit = 1'b1;
      end
    end
  end

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (fill_i && fill_hit) begin
        ent_d[fill_idx].inst = fill_inst_i;
        ent_d[fill_idx].done = 1'b1;
      end
      // Alloc is only granted when a slot is free, so the tail never aliases
      // the fill target or the head being popped.
      if (alloc_i) begin
        ent_d[tail_q] = '{pc: alloc_pc_i, inst: '0, adef: alloc_adef_i, done: alloc_adef_i};
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop_i) begin
        head_d = head_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < QDEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  // A pop this cycle does not free a slot until the count register updates.
  assign slot_free_o  = (cnt_q < CNT_W'(QDEPTH));
  assign head_valid_o = (cnt_q != '0) && ent_q[head_q].done;
  assign head_pc_o    = ent_q[head_q].pc;
  assign head_inst_o  = ent_q[head_q].inst;
  assign head_adef_o  = ent_q[head_q].adef;

endmodule

// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp
//   Responder side of the PC-generator fetch interface. Issues in-order reads
//   on an inst-SRAM-like bus (req/addr_ok/data_ok), buffers results in an
//   in-order queue and hands {pc, inst, adef} to decode with valid/pause.
//   Misaligned pcs (adef_i) bypass the bus and enter the queue already done.
//   A flush kills queued work; bus returns still owed for killed requests are
//   counted in discard_cnt and dropped when they arrive.
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   pc_i, inst_en_i, adef_i       fetch request from the PC stage
//   flush_i                       kill all queued / in-flight work
//   id_pause_i                    decode stalled, hold the head entry
//   inst_req_o, inst_addr_o       bus request (address = pc_i)
//   inst_addr_ok_i                bus took the address this cycle
//   inst_data_ok_i, inst_rdata_i  bus return, strictly in request order
//   fetch_stall_o                 PC stage must hold pc_i
//   id_valid_o, id_pc_o, id_inst_o, id_adef_o   head entry to decode
// Configuration
//   IFETCH_PERF_CNT_EN defined: adds perf_fetch_cnt_o (entries popped) and
//   perf_stall_cnt_o (cycles with fetch_stall_o high), both free-running
//   32-bit wrap-around counters cleared by reset.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INST_ADDR_W-1:0] pc_i,
  input  logic                   inst_en_i,
  input  logic                   adef_i,
  input  logic                   flush_i,
  input  logic                   id_pause_i,
  output logic                   inst_req_o,
  output logic [INST_ADDR_W-1:0] inst_addr_o,
  input  logic                   inst_addr_ok_i,
  input  logic                   inst_data_ok_i,
  input  logic [INST_W-1:0]      inst_rdata_i,
  output logic                   fetch_stall_o,
  output logic                   id_valid_o,
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0]      id_inst_o,
  output logic                   id_adef_o
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetch_cnt_o,
  output logic [31:0]            perf_stall_cnt_o
`endif
);

  localparam int               OCNT_W    = $clog2(MAX_OUT + 1);
  localparam logic [OCNT_W:0]  MAX_OUT_V = (OCNT_W + 1)'(MAX_OUT);

  logic [OCNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [OCNT_W-1:0] discard_cnt_q, discard_cnt_d;
  logic [OCNT_W:0]   inflight;
  logic              slot_free;
  logic              head_valid;
  logic              acc_bus;
  logic              acc_adef;
  logic              fill;
  logic              pop;

  // Killed-but-unreturned requests still occupy the bus, so they count
  // against the outstanding limit.
  assign inflight = {1'b0, out_cnt_q} + {1'b0, discard_cnt_q};

  // rst gating keeps the bus and decode quiet during the reset cycle itself,
  // before the synchronous clear has taken effect.
  assign inst_req_o    = rst & inst_en_i & ~adef_i & ~flush_i & slot_free & (inflight < MAX_OUT_V);
  assign inst_addr_o   = pc_i;
  assign acc_bus       = inst_req_o & inst_addr_ok_i;
  assign acc_adef      = rst & inst_en_i & adef_i & slot_free & ~flush_i;
  assign fetch_stall_o = inst_en_i & ~(acc_bus | acc_adef);

  assign fill       = inst_data_ok_i & (discard_cnt_q == '0) & ~flush_i;
  assign id_valid_o = rst & head_valid;
  assign pop        = id_valid_o & ~id_pause_i;

  always_comb begin
    out_cnt_d     = out_cnt_q;
    discard_cnt_d = discard_cnt_q;
    if (flush_i) begin
      // Everything still owed becomes discard; a return landing in the flush
      // cycle is one of those and is retired immediately.
      out_cnt_d     = '0;
      discard_cnt_d = discard_cnt_q + out_cnt_q - OCNT_W'(inst_data_ok_i);
    end else begin
      if (inst_data_ok_i) begin
        if (discard_cnt_q != '0) begin
          discard_cnt_d = discard_cnt_q - OCNT_W'(1);
        end else begin
          out_cnt_d = out_cnt_q - OCNT_W'(1);
        end
      end
      if (acc_bus) begin
        out_cnt_d = out_cnt_d + OCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_cnt_q     <= '0;
      discard_cnt_q <= '0;
    end else begin
      out_cnt_q     <= out_cnt_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  inst_fetch_resp_fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_fetch_queue (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .alloc_i      (acc_bus | acc_adef),
    .alloc_pc_i   (pc_i),
    .alloc_adef_i (acc_adef),
    .fill_i       (fill),
    .fill_inst_i  (inst_rdata_i),
    .pop_i        (pop),
    .slot_free_o  (slot_free),
    .head_valid_o (head_valid),
    .head_pc_o    (id_pc_o),
    .head_inst_o  (id_inst_o),
    .head_adef_o  (id_adef_o)
  );

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  always_comb begin
    perf_fetch_cnt_d = perf_fetch_cnt_q + 32'(pop);
    perf_stall_cnt_d = perf_stall_cnt_q + 32'(fetch_stall_o);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch_cnt_q <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_fetch_cnt_o = perf_fetch_cnt_q;
  assign perf_stall_cnt_o = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_resp.sv
// tb_inst_fetch_resp
//   Drives a PC stage, a randomised in-order bus and decode pause, and checks
//   every cycle against a queue-based reference model of the fetch responder.
module tb_inst_fetch_resp;

  localparam int QDEPTH  = 4;
  localparam int MAX_OUT = 2;

  logic        clk            = 1'b0;
  logic        rst            = 1'b0;
  logic [31:0] pc_i           = '0;
  logic        inst_en_i      = 1'b0;
  logic        adef_i         = 1'b0;
  logic        flush_i        = 1'b0;
  logic        id_pause_i     = 1'b0;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i = 1'b0;
  logic        inst_data_ok_i = 1'b0;
  logic [31:0] inst_rdata_i   = '0;
  logic        fetch_stall_o;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_adef_o;

  inst_fetch_resp #(
    .QDEPTH  (QDEPTH),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_i           (pc_i),
    .inst_en_i      (inst_en_i),
    .adef_i         (adef_i),
    .flush_i        (flush_i),
    .id_pause_i     (id_pause_i),
    .inst_req_o     (inst_req_o),
    .inst_addr_o    (inst_addr_o),
    .inst_addr_ok_i (inst_addr_ok_i),
    .inst_data_ok_i (inst_data_ok_i),
    .inst_rdata_i   (inst_rdata_i),
    .fetch_stall_o  (fetch_stall_o),
    .id_valid_o     (id_valid_o),
    .id_pc_o        (id_pc_o),
    .id_inst_o      (id_inst_o),
    .id_adef_o      (id_adef_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic        adef;
    logic        done;
  } exp_ent_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] ready;
  } bus_ent_t;

  exp_ent_t    mq[$];
  bus_ent_t    bq[$];
  int          m_out = 0;
  int          m_disc = 0;
  int          cyc = 0;
  int          p_en = 0, p_addr_ok = 100, p_data_ok = 100, p_pause = 0;
  int          p_flush = 0, p_adef = 0, lat_max = 0;
  logic        rst_req = 1'b0;
  logic        force_flush = 1'b0;
  logic [31:0] redirect_pc = 32'h1C00_0100;
  logic [31:0] next_pc = 32'h1C00_0000;
  logic        hold = 1'b0;
  int          pops = 0;
  int          adef_pops = 0;
  logic        watch_first = 1'b0;
  logic        first_seen = 1'b0;
  logic [31:0] first_pc = '0;

  function automatic logic roll(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // One clock: drive at negedge, check at negedge+1, advance model to the
  // state it must hold after the following posedge.
  task automatic step();
    logic exp_req, exp_acc, exp_stall, exp_valid, slot_free, dok, do_pop;
    int   n, k;
    @(negedge clk);
    rst = rst_req;
    if (!hold) begin
      inst_en_i = rst_req ? roll(p_en) : 1'b0;
      pc_i      = roll(p_adef) ? (next_pc | 32'($urandom_range(3, 1))) : next_pc;
    end
    adef_i         = (pc_i[1:0] != 2'b00);
    flush_i        = rst_req && (force_flush || roll(p_flush));
    id_pause_i     = roll(p_pause);
    inst_addr_ok_i = roll(p_addr_ok);
    dok = rst_req && (bq.size() > 0) && (int'(bq[0].ready) <= cyc) && roll(p_data_ok);
    inst_data_ok_i = dok;
    inst_rdata_i   = dok ? mem_word(bq[0].addr) : 32'hDEAD_BEEF;
    #1;

    n         = mq.size();
    slot_free = (n < QDEPTH);
    if (!rst_req) begin
      exp_req = 1'b0;
      exp_acc = 1'b0;
    end else begin
      exp_req = inst_en_i && !adef_i && !flush_i && slot_free && ((m_out + m_disc) < MAX_OUT);
      exp_acc = (exp_req && inst_addr_ok_i) || (inst_en_i && adef_i && slot_free && !flush_i);
    end
    exp_stall = inst_en_i && !exp_acc;
    exp_valid = (n > 0) && mq[0].done;

    check_eq("inst_req", 32'(inst_req_o), 32'(exp_req));
    check_eq("inst_addr", inst_addr_o, pc_i);
    check_eq("fetch_stall", 32'(fetch_stall_o), 32'(exp_stall));
    if (rst_req || n == 0) check_eq("id_valid", 32'(id_valid_o), 32'(exp_valid));
    if (rst_req && exp_valid) begin
      check_eq("id_pc", id_pc_o, mq[0].pc);
      check_eq("id_inst", id_inst_o, mq[0].adef ? 32'h0 : mem_word(mq[0].pc));
      check_eq("id_adef", 32'(id_adef_o), 32'(mq[0].adef));
    end

    do_pop = rst_req && !flush_i && exp_valid && !id_pause_i;
    if (do_pop && watch_first && !first_seen) begin
      first_seen = 1'b1;
      first_pc   = id_pc_o;
    end

    if (!rst_req) begin
      mq.delete();
      bq.delete();
      m_out  = 0;
      m_disc = 0;
    end else if (flush_i) begin
      if (dok) void'(bq.pop_front());
      m_disc = m_disc + m_out - (dok ? 1 : 0);
      m_out  = 0;
      mq.delete();
    end else begin
      if (dok) begin
        void'(bq.pop_front());
        if (m_disc > 0) begin
          m_disc--;
        end else begin
          k = -1;
          for (int i = 0; i < mq.size(); i++) begin
            if (k < 0 && !mq[i].done) k = i;
          end
          check_eq("fill_target", 32'(k >= 0), 32'd1);
          if (k >= 0) mq[k].done = 1'b1;
          m_out--;
        end
      end
      if (do_pop) begin
        pops++;
        if (mq[0].adef) adef_pops++;
        void'(mq.pop_front());
      end
      if (exp_acc) begin
        mq.push_back('{pc: pc_i, adef: adef_i, done: adef_i});
        if (!adef_i) m_out++;
      end
    end
    if (exp_req && inst_addr_ok_i) begin
      bq.push_back('{addr: pc_i, ready: 32'(cyc + 1 + int'($urandom_range(lat_max))) });
    end

    if (flush_i) begin
      hold    = 1'b0;
      next_pc = redirect_pc;
    end else begin
      hold = inst_en_i && !exp_acc;
      if (exp_acc) next_pc = {pc_i[31:2], 2'b00} + 32'd4;
    end
    cyc++;
  endtask

  task automatic set_knobs(input int en, input int aok, input int dok, input int pause,
                           input int fl, input int adef, input int lat);
    p_en = en; p_addr_ok = aok; p_data_ok = dok; p_pause = pause;
    p_flush = fl; p_adef = adef; lat_max = lat;
  endtask

  initial begin
    int start_pops;

    // reset
    rst_req = 1'b0;
    set_knobs(0, 100, 100, 0, 0, 0, 0);
    repeat (3) step();
    check_eq("rst_valid", 32'(id_valid_o), 32'd0);
    check_eq("rst_req", 32'(inst_req_o), 32'd0);
    rst_req = 1'b1;
    next_pc = 32'h1C00_0000;

    // stream: one instruction per cycle
    set_knobs(100, 100, 100, 0, 0, 0, 0);
    start_pops = pops;
    repeat (40) step();
    check_eq("stream_rate", 32'((pops - start_pops) >= 35), 32'd1);

    // decode pause fills the queue and back-pressures
    p_pause = 100;
    repeat (10) step();
    check_eq("pause_full_stall", 32'(fetch_stall_o), 32'd1);
    check_eq("pause_full_req", 32'(inst_req_o), 32'd0);
    p_pause = 0;
    repeat (20) step();

    // flush with two requests outstanding
    set_knobs(100, 100, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && m_out != MAX_OUT; i++) step();
    check_eq("flush_setup_out", 32'(m_out), 32'(MAX_OUT));
    redirect_pc = 32'h1C00_0100;
    force_flush = 1'b1;
    watch_first = 1'b1;
    first_seen  = 1'b0;
    step();
    force_flush = 1'b0;
    p_data_ok   = 100;
    for (int i = 0; i < 40 && !first_seen; i++) step();
    check_eq("flush_first_seen", 32'(first_seen), 32'd1);
    check_eq("flush_first_pc", first_pc, 32'h1C00_0100);
    watch_first = 1'b0;

    // misaligned pcs mixed in
    set_knobs(100, 100, 100, 10, 0, 30, 1);
    repeat (60) step();
    check_eq("adef_seen", 32'(adef_pops > 0), 32'd1);

    // reset mid-transaction
    set_knobs(100, 100, 40, 100, 0, 0, 2);
    for (int i = 0; i < 50 && !(mq.size() >= 2 && m_out == MAX_OUT); i++) step();
    check_eq("rst_mid_setup", 32'(mq.size() >= 2 && m_out == MAX_OUT), 32'd1);
    rst_req = 1'b0;
    step();
    step();
    check_eq("rst_mid_valid", 32'(id_valid_o), 32'd0);
    check_eq("rst_mid_req", 32'(inst_req_o), 32'd0);
    rst_req = 1'b1;
    set_knobs(0, 100, 100, 0, 0, 0, 0);
    repeat (15) step();

    // addr_ok held low: stall throughout, then a single accept
    set_knobs(100, 0, 100, 0, 0, 0, 0);
    repeat (5) begin
      step();
      check_eq("aok_low_stall", 32'(fetch_stall_o), 32'd1);
      check_eq("aok_low_req", 32'(inst_req_o), 32'd1);
    end
    p_addr_ok = 100;
    step();
    check_eq("aok_high_stall", 32'(fetch_stall_o), 32'd0);
    repeat (10) step();

    // random mix
    for (int blk = 0; blk < 15; blk++) begin
      set_knobs(int'($urandom_range(100, 50)), int'($urandom_range(100, 30)),
                int'($urandom_range(100, 30)), int'($urandom_range(60)),
                int'($urandom_range(5)), int'($urandom_range(20)), int'($urandom_range(3)));
      redirect_pc = 32'h1C00_0000 + (32'($urandom_range(255)) << 2);
      repeat (100) step();
      if (blk % 4 == 3) begin
        rst_req = 1'b0;
        repeat (2) step();
        rst_req = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
